// File: rtl/ea_pkg.sv
// Shared constants for the effective-address sequencer: addressing modes,
// operand sizes, FSM state encodings and the stack-pointer register number.
package ea_pkg;

  localparam logic [1:0] MODE_IND     = 2'b00;
  localparam logic [1:0] MODE_POSTINC = 2'b01;
  localparam logic [1:0] MODE_PREDEC  = 2'b10;
  localparam logic [1:0] MODE_DISP    = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b01;
  localparam logic [1:0] SIZE_LONG = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CALC  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ISSUE = 3'd4;

  localparam logic [2:0] SP_REG = 3'd7;

endpackage

// File: rtl/ea_increment.sv
// Post-increment / pre-decrement step for a given operand size and register.
// Byte accesses through A7 step by 2 so the stack pointer stays word aligned.
module ea_increment
  import ea_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [1:0]        size,
  input  logic [2:0]        reg_sel,
  output logic [ADDR_W-1:0] inc_c
);

  always_comb begin
    inc_c = ADDR_W'(4);
    case (size)
      SIZE_BYTE: inc_c = (reg_sel == SP_REG) ? ADDR_W'(2) : ADDR_W'(1);
      SIZE_WORD: inc_c = ADDR_W'(2);
      default:   inc_c = ADDR_W'(4);
    endcase
  end

endmodule

// File: rtl/ea_address_unit.sv
// Effective-address sequencer: reads An, forms the EA for (An), (An)+, -(An)
// and d16(An), writes back the updated An, then offers the EA with valid/ready.
module ea_address_unit
  import ea_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DISP_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [2:0]        REG_SEL,
  input  logic [1:0]        MODE,
  input  logic [1:0]        SIZE,
  input  logic [DISP_W-1:0] DISP,
  input  logic              SUPERVISOR_MODE,
  input  logic [ADDR_W-1:0] RF_Q,
  output logic [2:0]        RF_SEL,
  output logic              RF_SUPERVISOR,
  output logic              RF_S,
  output logic [ADDR_W-1:0] RF_D,
  output logic [ADDR_W-1:0] EA,
  output logic              EA_VALID,
  input  logic              EA_READY,
  output logic              BUSY,
  output logic              ADDR_ERR
);

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        size_q, size_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [2:0]        rf_sel_d;
  logic              rf_sup_d;
  logic              rf_s_d;
  logic [ADDR_W-1:0] rf_d_d;
  logic [ADDR_W-1:0] ea_d;
  logic              ea_valid_d;
  logic              busy_d;
  logic              addr_err_d;

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] ea_calc;
  logic [ADDR_W-1:0] wb_calc;
  logic              wb_needed;
  logic              misaligned;

  ea_increment #(.ADDR_W(ADDR_W)) u_inc (
    .size    (size_q),
    .reg_sel (RF_SEL),
    .inc_c   (inc)
  );

  assign disp_ext = {{(ADDR_W-DISP_W){disp_q[DISP_W-1]}}, disp_q};

  // Address arithmetic for the captured mode; all sums wrap modulo 2^ADDR_W.
  always_comb begin
    ea_calc   = base_q;
    wb_calc   = base_q;
    wb_needed = 1'b0;
    case (mode_q)
      MODE_POSTINC: begin
        wb_calc   = base_q + inc;
        wb_needed = 1'b1;
      end
      MODE_PREDEC: begin
        ea_calc   = base_q - inc;
        wb_calc   = base_q - inc;
        wb_needed = 1'b1;
      end
      MODE_DISP: ea_calc = base_q + disp_ext;
      default:   ea_calc = base_q;
    endcase
    misaligned = (size_q != SIZE_BYTE) && ea_calc[0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    size_d     = size_q;
    disp_d     = disp_q;
    base_d     = base_q;
    rf_sel_d   = RF_SEL;
    rf_sup_d   = RF_SUPERVISOR;
    rf_s_d     = 1'b0;
    rf_d_d     = RF_D;
    ea_d       = EA;
    ea_valid_d = EA_VALID;
    busy_d     = BUSY;
    addr_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          rf_sel_d = REG_SEL;
          rf_sup_d = SUPERVISOR_MODE;
          mode_d   = MODE;
          size_d   = SIZE;
          disp_d   = DISP;
          busy_d   = 1'b1;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        base_d  = RF_Q;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        if (misaligned) begin
          addr_err_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else if (wb_needed) begin
          ea_d    = ea_calc;
          rf_d_d  = wb_calc;
          rf_s_d  = 1'b1;
          state_d = ST_WRITE;
        end else begin
          ea_d       = ea_calc;
          ea_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_WRITE: begin
        ea_valid_d = 1'b1;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (EA_READY) begin
          ea_valid_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        ea_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_IND;
      size_q        <= SIZE_BYTE;
      disp_q        <= '0;
      base_q        <= '0;
      RF_SEL        <= 3'd0;
      RF_SUPERVISOR <= 1'b0;
      RF_S          <= 1'b0;
      RF_D          <= '0;
      EA            <= '0;
      EA_VALID      <= 1'b0;
      BUSY          <= 1'b0;
      ADDR_ERR      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      size_q        <= size_d;
      disp_q        <= disp_d;
      base_q        <= base_d;
      RF_SEL        <= rf_sel_d;
      RF_SUPERVISOR <= rf_sup_d;
      RF_S          <= rf_s_d;
      RF_D          <= rf_d_d;
      EA            <= ea_d;
      EA_VALID      <= ea_valid_d;
      BUSY          <= busy_d;
      ADDR_ERR      <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_ea_address_unit.sv
// Directed bench for ea_address_unit: each step drives one operation and checks
// outputs 1ns after each rising edge against hand-computed values.
module tb_ea_address_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [2:0]  REG_SEL;
  logic [1:0]  MODE;
  logic [1:0]  SIZE;
  logic [15:0] DISP;
  logic        SUPERVISOR_MODE;
  logic [31:0] RF_Q;
  logic [2:0]  RF_SEL;
  logic        RF_SUPERVISOR;
  logic        RF_S;
  logic [31:0] RF_D;
  logic [31:0] EA;
  logic        EA_VALID;
  logic        EA_READY;
  logic        BUSY;
  logic        ADDR_ERR;

  int n_assert = 0;
  int n_fail   = 0;
  int rf_s_cnt = 0;
  int ev_cnt   = 0;
  int rf_s_base;
  int ev_base;

  ea_address_unit #(.ADDR_W(32), .DISP_W(16)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .START           (START),
    .REG_SEL         (REG_SEL),
    .MODE            (MODE),
    .SIZE            (SIZE),
    .DISP            (DISP),
    .SUPERVISOR_MODE (SUPERVISOR_MODE),
    .RF_Q            (RF_Q),
    .RF_SEL          (RF_SEL),
    .RF_SUPERVISOR   (RF_SUPERVISOR),
    .RF_S            (RF_S),
    .RF_D            (RF_D),
    .EA              (EA),
    .EA_VALID        (EA_VALID),
    .EA_READY        (EA_READY),
    .BUSY            (BUSY),
    .ADDR_ERR        (ADDR_ERR)
  );

  always #5 CLK = ~CLK;

  // Count cycles in which the store strobe / EA_VALID are high.
  always @(posedge CLK) begin
    if (RF_S)     rf_s_cnt <= rf_s_cnt + 1;
    if (EA_VALID) ev_cnt   <= ev_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives a request; the edge inside this task is edge 0 (samples START).
  task automatic start_op(input logic [2:0] n, input logic [1:0] m, input logic [1:0] s,
                          input logic [15:0] d, input logic sup, input logic [31:0] q);
    REG_SEL = n; MODE = m; SIZE = s; DISP = d; SUPERVISOR_MODE = sup; RF_Q = q;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; REG_SEL = 3'd0; MODE = 2'b00; SIZE = 2'b00;
    DISP = 16'h0; SUPERVISOR_MODE = 1'b0; RF_Q = 32'h0; EA_READY = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_ea_valid", 32'(EA_VALID), 32'h0);
    chk("rst_rf_s", 32'(RF_S), 32'h0);
    chk("rst_ea", EA, 32'h0);
    chk("rst_rf_d", RF_D, 32'h0);
    RESET = 1'b0;
    tick();

    // (An)+ long, A2 = 0x1000
    rf_s_base = rf_s_cnt;
    start_op(3'd2, 2'b01, 2'b10, 16'h0, 1'b0, 32'h0000_1000);
    chk("pi_busy_e0", 32'(BUSY), 32'h1);
    chk("pi_rf_sel", 32'(RF_SEL), 32'h2);
    tick();
    chk("pi_ev_e1", 32'(EA_VALID), 32'h0);
    tick();
    chk("pi_rf_s_e2", 32'(RF_S), 32'h1);
    chk("pi_rf_d", RF_D, 32'h0000_1004);
    chk("pi_ev_e2", 32'(EA_VALID), 32'h0);
    tick();
    chk("pi_rf_s_e3", 32'(RF_S), 32'h0);
    chk("pi_ev_e3", 32'(EA_VALID), 32'h1);
    chk("pi_ea", EA, 32'h0000_1000);
    chk("pi_busy_e3", 32'(BUSY), 32'h1);
    tick();
    chk("pi_ev_e4", 32'(EA_VALID), 32'h0);
    chk("pi_busy_e4", 32'(BUSY), 32'h0);
    chk("pi_rf_s_count", 32'(rf_s_cnt - rf_s_base), 32'h1);
    tick();

    // -(A7) byte in supervisor mode: step of 2 keeps SP even
    start_op(3'd7, 2'b10, 2'b00, 16'h0, 1'b1, 32'h0000_2000);
    chk("pd_rf_sup", 32'(RF_SUPERVISOR), 32'h1);
    tick(); tick();
    chk("pd_rf_s", 32'(RF_S), 32'h1);
    chk("pd_rf_d", RF_D, 32'h0000_1FFE);
    tick();
    chk("pd_ev", 32'(EA_VALID), 32'h1);
    chk("pd_ea", EA, 32'h0000_1FFE);
    tick(); tick();

    // d16(A3) word, negative displacement, no write-back
    rf_s_base = rf_s_cnt;
    start_op(3'd3, 2'b11, 2'b01, 16'hFFF0, 1'b0, 32'h0000_0100);
    chk("dp_rf_sup", 32'(RF_SUPERVISOR), 32'h0);
    tick();
    chk("dp_ev_e1", 32'(EA_VALID), 32'h0);
    tick();
    chk("dp_ev_e2", 32'(EA_VALID), 32'h1);
    chk("dp_ea", EA, 32'h0000_00F0);
    tick();
    chk("dp_busy_e3", 32'(BUSY), 32'h0);
    chk("dp_rf_s_count", 32'(rf_s_cnt - rf_s_base), 32'h0);
    tick();

    // (A1) word at odd address: address error
    rf_s_base = rf_s_cnt;
    ev_base   = ev_cnt;
    start_op(3'd1, 2'b00, 2'b01, 16'h0, 1'b0, 32'h0000_0101);
    tick(); tick();
    chk("ae_pulse", 32'(ADDR_ERR), 32'h1);
    chk("ae_ev", 32'(EA_VALID), 32'h0);
    tick();
    chk("ae_pulse_end", 32'(ADDR_ERR), 32'h0);
    chk("ae_busy_e3", 32'(BUSY), 32'h0);
    chk("ae_rf_s_count", 32'(rf_s_cnt - rf_s_base), 32'h0);
    chk("ae_ev_count", 32'(ev_cnt - ev_base), 32'h0);
    tick();

    // Back-pressure: EA held for 5 cycles, a START meanwhile is dropped
    EA_READY = 1'b0;
    start_op(3'd4, 2'b00, 2'b10, 16'h0, 1'b0, 32'h0000_4000);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        REG_SEL = 3'd5; MODE = 2'b11; START = 1'b1;
      end else begin
        START = 1'b0;
      end
      tick();
      chk("bp_ev", 32'(EA_VALID), 32'h1);
      chk("bp_ea", EA, 32'h0000_4000);
      chk("bp_rf_sel", 32'(RF_SEL), 32'h4);
    end
    START = 1'b0;
    EA_READY = 1'b1;
    tick();
    chk("bp_release_ev", 32'(EA_VALID), 32'h0);
    chk("bp_release_busy", 32'(BUSY), 32'h0);
    tick();
    chk("bp_not_queued", 32'(BUSY), 32'h0);

    // Reset asserted while in WRITE
    start_op(3'd2, 2'b01, 2'b10, 16'h0, 1'b0, 32'h0000_1000);
    tick(); tick();
    chk("rw_in_write", 32'(RF_S), 32'h1);
    RESET = 1'b1;
    #1;
    chk("rw_rf_s", 32'(RF_S), 32'h0);
    chk("rw_rf_d", RF_D, 32'h0);
    chk("rw_busy", 32'(BUSY), 32'h0);
    chk("rw_rf_sel", 32'(RF_SEL), 32'h0);
    tick();
    RESET = 1'b0;
    rf_s_base = rf_s_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("rw_no_late_rf_s", 32'(rf_s_cnt - rf_s_base), 32'h0);
    chk("rw_idle", 32'(BUSY), 32'h0);

    // Wrap-around: -(A0) long from 0, and (A6)+ word from 0xFFFFFFFE
    start_op(3'd0, 2'b10, 2'b10, 16'h0, 1'b0, 32'h0000_0000);
    tick(); tick();
    chk("wr_pd_rf_d", RF_D, 32'hFFFF_FFFC);
    tick();
    chk("wr_pd_ea", EA, 32'hFFFF_FFFC);
    tick(); tick();
    start_op(3'd6, 2'b01, 2'b01, 16'h0, 1'b0, 32'hFFFF_FFFE);
    tick(); tick();
    chk("wr_pi_rf_d", RF_D, 32'h0000_0000);
    tick();
    chk("wr_pi_ea", EA, 32'hFFFF_FFFE);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ea_address_unit.md
Name: ea_address_unit

Overview:
- Effective-address sequencer sitting directly upstream of the address register file.
- Reads An and computes the effective address for the (An), (An)+, -(An) and d16(An) addressing modes.
- For (An)+ and -(An), writes the updated An back through the register file's select/store port.
- Presents the final EA to the bus interface with a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of address registers and EA.
- DISP_W, 16, width of displacement input; sign-extended to ADDR_W.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request pulse; sampled only when BUSY=0.
- REG_SEL  in  3  address register number n.
- MODE  in  2  00 (An), 01 (An)+, 10 -(An), 11 d16(An).
- SIZE  in  2  00 byte, 01 word, 10 long, 11 treated as long.
- DISP  in  DISP_W  displacement for d16(An).
- SUPERVISOR_MODE  in  1  privilege level; sampled with START.
- RF_Q  in  ADDR_W  register file read data; valid one clock after RF_SEL changes.
- RF_SEL  out  3  register select to the register file.
- RF_SUPERVISOR  out  1  registered privilege, forwarded to the register file so A7 selects SSP or USP.
- RF_S  out  1  one-cycle store strobe to the register file.
- RF_D  out  ADDR_W  write-back data.
- EA  out  ADDR_W  effective address.
- EA_VALID  out  1  EA valid; held until accepted.
- EA_READY  in  1  bus interface accepts EA.
- BUSY  out  1  high in any state other than IDLE.
- ADDR_ERR  out  1  one-cycle pulse on misaligned word/long EA.

Behaviour:
- Reset (asynchronous):
  - state returns to IDLE.
  - RF_SEL, RF_SUPERVISOR, RF_S, RF_D, EA, EA_VALID, BUSY and ADDR_ERR all go to 0.
  - Any in-flight write-back is abandoned; RF_S is never asserted after reset until a new START.
- States: IDLE, READ, CALC, WRITE, ISSUE. All outputs are registered.
- IDLE:
  - On START=1, capture REG_SEL, MODE, SIZE, DISP and SUPERVISOR_MODE.
  - Drive RF_SEL and RF_SUPERVISOR, then go to READ.
  - START while BUSY=1 is ignored, not queued.
- READ: latch RF_Q into base register, then go to CALC.
- CALC: compute increment inc.
  - byte: 1, except byte with n=7, which uses 2 to keep the stack even.
  - word: 2.
  - long (SIZE 10 or 11): 4.
- CALC per mode, all arithmetic modulo 2^ADDR_W:
  - (An): EA = base; no write-back.
  - (An)+: EA = base; RF_D = base + inc.
  - -(An): EA = base - inc; RF_D = EA.
  - d16(An): EA = base + sign_extend(DISP); no write-back.
- Alignment check: if SIZE != byte and EA[0] = 1:
  - Pulse ADDR_ERR for one cycle and go to IDLE.
  - No write-back and no EA_VALID.
- CALC exit:
  - Otherwise go to WRITE for modes 01 and 10.
  - Go to ISSUE for modes 00 and 11.
- WRITE: RF_S=1 for exactly one cycle with RF_SEL and RF_D stable, then go to ISSUE.
- ISSUE:
  - EA_VALID=1 with EA stable.
  - On the edge where EA_VALID and EA_READY are both 1, go to IDLE; EA_VALID falls after that edge.
  - EA_READY while not in ISSUE has no effect.
- Latency, counting from the edge that samples START:
  - EA_VALID first high after edge 2 without write-back, or after edge 3 with write-back.
  - With EA_READY tied high, BUSY falls after edge 3 without write-back, or edge 4 with write-back.
- Wrap-around:
  - -(An) with An=0x00000000, long: EA = 0xFFFFFFFC.
  - (An)+ with An=0xFFFFFFFE, word: RF_D = 0x00000000.
- RF_SEL holds the captured value from IDLE exit until the next START.

Decomposition:
- Package ea_pkg holds:
  - MODE_IND, MODE_POSTINC, MODE_PREDEC, MODE_DISP.
  - SIZE_BYTE, SIZE_WORD, SIZE_LONG.
  - State encodings.
  - SP_REG = 3'd7.
- One sub-module, ea_increment: combinational (SIZE, REG_SEL) -> inc, so the A7 byte rule is tested in isolation.

Test Plan:
- Postincrement: MODE=01, SIZE=10, n=2, RF_Q=0x00001000, EA_READY=1 -> RF_S pulse with RF_D=0x00001004; EA=0x00001000 with EA_VALID after edge 3.
- Predecrement on A7: MODE=10, SIZE=00, n=7, RF_Q=0x00002000, SUPERVISOR_MODE=1 -> RF_SUPERVISOR=1, RF_D=EA=0x00001FFE.
- Displacement: MODE=11, DISP=0xFFF0, RF_Q=0x00000100 -> EA=0x000000F0, RF_S never asserted, EA_VALID after edge 2.
- Address error: MODE=00, SIZE=01, RF_Q=0x00000101 -> one-cycle ADDR_ERR, no RF_S, no EA_VALID, BUSY low after edge 3.
- Back-pressure and reset: EA_READY=0 for 5 cycles -> EA_VALID and EA held stable; START in this window is ignored. In a separate run, asserting RESET while in WRITE -> all outputs 0 immediately and no later RF_S.
- Wrap: MODE=10, SIZE=10, RF_Q=0x00000000 -> EA=RF_D=0xFFFFFFFC.
